// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the MEM stage and its watchdog.
//   mem_state_t : MEM stage FSM states (IDLE, WAIT_ACK)
//   mem_xact_t  : one memory transaction latched at accept time. It holds the
//                 bus request fields and the MEM/WB pass-through fields.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic              wbs;
        logic              ni;
        logic              reg_dest;
        logic              reg_dest_data_writeback;
        logic [DATA_W-1:0] calc;
    } mem_xact_t;

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts cycles spent waiting for a memory acknowledge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count. This has priority over enable.
//   enable     : advance the count by one this cycle.
//   tc         : terminal count. The count equals TIMEOUT-1.
module mem_watchdog #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    import cpu_pkg::*;

    // A one-bit counter is used even when TIMEOUT==1, because $clog2(1) is 0.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 1'b1;
    end

    assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM stage of the 16-bit pipelined CPU.
// It accepts an instruction from EX/MEM. Loads and stores go to data memory
// over a req/ack handshake, and upstream is stalled while a transfer is open.
// The stage then drives the MEM/WB register inputs.
//   clk, rst_n                : clock, asynchronous active-low reset
//   ex_*                      : EX/MEM register contents
//   flush_in                  : squash the instruction currently in MEM
//   dmem_req/we/addr/wdata    : data-memory request (registered)
//   dmem_rdata, dmem_ack      : memory response
//   stall_out                 : hold EX/MEM and earlier stages (combinational)
//   mem_fault                 : sticky flag; a transfer timed out
//   wb_valid, *_out           : MEM/WB inputs (registered)
module memory_access_stage #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [DATA_W-1:0] ex_calc_data,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_wbs,
    input  logic              ex_ni,
    input  logic              ex_reg_dest,
    input  logic              ex_reg_dest_data_writeback,
    input  logic              flush_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_out,
    output logic              mem_fault,
    output logic              wb_valid,
    output logic              wbs_out,
    output logic              ni_out,
    output logic              reg_dest_out,
    output logic              reg_dest_data_writeback_out,
    output logic [DATA_W-1:0] memData_out,
    output logic [DATA_W-1:0] calcData_out
);
    import cpu_pkg::*;

    mem_state_t state;
    mem_xact_t  xact;
    logic       kill;
    logic       wd_tc;

    logic in_wait, mem_op, accept, timeout_hit, done, kill_eff;

    assign in_wait     = (state == WAIT_ACK);
    assign mem_op      = ex_mem_read | ex_mem_write;
    assign accept      = (state == IDLE) & ex_valid & mem_op & ~flush_in;
    // If ack and timeout arrive together, ack wins.
    assign timeout_hit = in_wait & wd_tc & ~dmem_ack;
    assign done        = in_wait & (dmem_ack | timeout_hit);
    // A flush arriving in the completing cycle still squashes the result.
    assign kill_eff    = kill | flush_in;

    // Stall drops in the completing cycle, so EX/MEM advances at that edge.
    // Gating with rst_n keeps stall low while reset is held.
    assign stall_out = rst_n & (accept | (in_wait & ~done));

    // Bus request fields come straight from the latched transaction.
    // They therefore stay stable for the whole wait.
    assign dmem_we    = xact.we;
    assign dmem_addr  = xact.addr;
    assign dmem_wdata = xact.wdata;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (~in_wait),
        .enable (in_wait),
        .tc     (wd_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                       <= IDLE;
            xact                        <= '0;
            kill                        <= 1'b0;
            dmem_req                    <= 1'b0;
            mem_fault                   <= 1'b0;
            wb_valid                    <= 1'b0;
            wbs_out                     <= 1'b0;
            ni_out                      <= 1'b0;
            reg_dest_out                <= 1'b0;
            reg_dest_data_writeback_out <= 1'b0;
            memData_out                 <= '0;
            calcData_out                <= '0;
        end else begin
            // Bubble by default. The other MEM/WB fields hold their last values.
            wb_valid <= 1'b0;
            wbs_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid && !flush_in) begin
                        if (mem_op) begin
                            state    <= WAIT_ACK;
                            dmem_req <= 1'b1;
                            xact     <= '{addr:  ex_calc_data[ADDR_W-1:0],
                                          wdata: ex_store_data,
                                          we:    ex_mem_write,
                                          wbs:   ex_wbs,
                                          ni:    ex_ni,
                                          reg_dest: ex_reg_dest,
                                          reg_dest_data_writeback: ex_reg_dest_data_writeback,
                                          calc:  ex_calc_data};
                        end else begin
                            wb_valid                    <= 1'b1;
                            wbs_out                     <= ex_wbs;
                            ni_out                      <= ex_ni;
                            reg_dest_out                <= ex_reg_dest;
                            reg_dest_data_writeback_out <= ex_reg_dest_data_writeback;
                            calcData_out                <= ex_calc_data;
                            memData_out                 <= '0;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (flush_in) kill <= 1'b1;
                    if (done) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        kill     <= 1'b0;
                        if (timeout_hit) mem_fault <= 1'b1;
                        if (!kill_eff) begin
                            wb_valid                    <= 1'b1;
                            // A timed-out load has no data, so its writeback is suppressed.
                            wbs_out                     <= xact.wbs & dmem_ack;
                            ni_out                      <= xact.ni;
                            reg_dest_out                <= xact.reg_dest;
                            reg_dest_data_writeback_out <= xact.reg_dest_data_writeback;
                            calcData_out                <= xact.calc;
                            memData_out                 <= (dmem_ack && !xact.we) ? dmem_rdata : '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [15:0] ex_calc_data, ex_store_data;
    logic        ex_wbs, ex_ni, ex_reg_dest, ex_reg_dest_data_writeback;
    logic        flush_in;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall_out, mem_fault, wb_valid, wbs_out, ni_out;
    logic        reg_dest_out, reg_dest_data_writeback_out;
    logic [15:0] memData_out, calcData_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_access_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_calc_data(ex_calc_data), .ex_store_data(ex_store_data),
        .ex_wbs(ex_wbs), .ex_ni(ex_ni), .ex_reg_dest(ex_reg_dest),
        .ex_reg_dest_data_writeback(ex_reg_dest_data_writeback),
        .flush_in(flush_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out), .mem_fault(mem_fault), .wb_valid(wb_valid),
        .wbs_out(wbs_out), .ni_out(ni_out), .reg_dest_out(reg_dest_out),
        .reg_dest_data_writeback_out(reg_dest_data_writeback_out),
        .memData_out(memData_out), .calcData_out(calcData_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0;
        ex_calc_data = 0; ex_store_data = 0;
        ex_wbs = 0; ex_ni = 0; ex_reg_dest = 0; ex_reg_dest_data_writeback = 0;
        flush_in = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic put_load(input logic [15:0] a);
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0;
        ex_calc_data = a; ex_wbs = 1;
    endtask

    initial begin
        clr_in();
        rst_n = 0;
        cyc(); cyc();
        chk("rst_req",   dmem_req,    0);
        chk("rst_stall", stall_out,   0);
        chk("rst_wbv",   wb_valid,    0);
        chk("rst_fault", mem_fault,   0);
        chk("rst_mdata", memData_out, 0);
        rst_n = 1;
        cyc();

        // 1: ALU op passes through in one cycle
        ex_valid = 1; ex_calc_data = 16'h1234; ex_wbs = 1; ex_ni = 1; ex_reg_dest = 1;
        #1 chk("alu_stall", stall_out, 0);
        cyc();
        chk("alu_wbv",  wb_valid,     1);
        chk("alu_calc", calcData_out, 16'h1234);
        chk("alu_wbs",  wbs_out,      1);
        chk("alu_ni",   ni_out,       1);
        chk("alu_rd",   reg_dest_out, 1);
        chk("alu_mdat", memData_out,  0);
        chk("alu_req",  dmem_req,     0);
        clr_in();
        cyc();
        chk("alu_bub_wbv",  wb_valid,     0);
        chk("alu_bub_wbs",  wbs_out,      0);
        chk("alu_bub_calc", calcData_out, 16'h1234);

        // 2: load 0x0040, ack on 3rd wait cycle
        put_load(16'h0040);
        #1 chk("ld_stall0", stall_out, 1);
        cyc();
        chk("ld_req1",  dmem_req,  1);
        chk("ld_addr",  dmem_addr, 16'h0040);
        chk("ld_we",    dmem_we,   0);
        chk("ld_wbv1",  wb_valid,  0);
        chk("ld_stall1", stall_out, 1);
        cyc();
        chk("ld_req2",   dmem_req,  1);
        chk("ld_stall2", stall_out, 1);
        cyc();
        dmem_ack = 1; dmem_rdata = 16'hBEEF;
        #1 chk("ld_stall3", stall_out, 0);
        chk("ld_req3", dmem_req, 1);
        cyc();
        clr_in();
        #1;
        chk("ld_wbv",  wb_valid,     1);
        chk("ld_mdat", memData_out,  16'hBEEF);
        chk("ld_wbs",  wbs_out,      1);
        chk("ld_calc", calcData_out, 16'h0040);
        chk("ld_reqd", dmem_req,     0);
        cyc();
        chk("ld_bub", wb_valid, 0);

        // 3: store 0x00FF to 0x0010, ack on 1st wait cycle
        ex_valid = 1; ex_mem_write = 1; ex_calc_data = 16'h0010; ex_store_data = 16'h00FF;
        #1 chk("st_stall0", stall_out, 1);
        cyc();
        chk("st_req",   dmem_req,   1);
        chk("st_we",    dmem_we,    1);
        chk("st_wdata", dmem_wdata, 16'h00FF);
        chk("st_addr",  dmem_addr,  16'h0010);
        dmem_ack = 1;
        #1 chk("st_stall1", stall_out, 0);
        cyc();
        clr_in();
        #1;
        chk("st_wbv",  wb_valid,     1);
        chk("st_mdat", memData_out,  0);
        chk("st_calc", calcData_out, 16'h0010);
        cyc();
        chk("st_bub", wb_valid, 0);

        // 4: timeout with no ack; request is held for exactly 8 cycles
        put_load(16'h0020);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk("to_req",   dmem_req,  1);
            chk("to_stall", stall_out, (i != 7));
            if (i < 7) cyc();
        end
        cyc();
        clr_in();
        #1;
        chk("to_reqd",  dmem_req,    0);
        chk("to_fault", mem_fault,   1);
        chk("to_wbv",   wb_valid,    1);
        chk("to_wbs",   wbs_out,     0);
        chk("to_mdat",  memData_out, 0);
        cyc();
        chk("to_sticky", mem_fault, 1);

        // 5: flush in 2nd wait cycle, ack in 4th -> result squashed
        put_load(16'h0030);
        cyc();                       // W1
        cyc();                       // W2
        flush_in = 1;
        #1 chk("fl_stall2", stall_out, 1);
        cyc();                       // W3
        flush_in = 0;
        #1 chk("fl_req3", dmem_req, 1);
        cyc();                       // W4
        dmem_ack = 1; dmem_rdata = 16'h1111;
        #1 chk("fl_stall4", stall_out, 0);
        cyc();
        clr_in();
        #1;
        chk("fl_wbv",  wb_valid,     0);
        chk("fl_wbs",  wbs_out,      0);
        chk("fl_calc", calcData_out, 16'h0020);
        chk("fl_mdat", memData_out,  0);
        ex_valid = 1; ex_calc_data = 16'h5555; ex_wbs = 1;
        cyc();
        clr_in();
        #1;
        chk("fl_alu_wbv",  wb_valid,     1);
        chk("fl_alu_calc", calcData_out, 16'h5555);
        chk("fl_alu_wbs",  wbs_out,      1);

        // 6: reset mid-transfer, then back-to-back loads
        put_load(16'h0044);
        cyc();
        chk("rs_req_pre", dmem_req, 1);
        rst_n = 0;
        #1;
        chk("rs_req",   dmem_req,  0);
        chk("rs_stall", stall_out, 0);
        chk("rs_wbv",   wb_valid,  0);
        chk("rs_fault", mem_fault, 0);
        cyc();
        clr_in();
        rst_n = 1;
        cyc();
        chk("rs_noreissue", dmem_req, 0);
        put_load(16'h0100);
        cyc();
        chk("bb_addrA", dmem_addr, 16'h0100);
        dmem_ack = 1; dmem_rdata = 16'hAAAA;
        cyc();
        dmem_ack = 0; ex_calc_data = 16'h0102;
        #1;
        chk("bb_wbvA",   wb_valid,     1);
        chk("bb_mdatA",  memData_out,  16'hAAAA);
        chk("bb_calcA",  calcData_out, 16'h0100);
        chk("bb_reqA",   dmem_req,     0);
        chk("bb_stallB", stall_out,    1);
        cyc();
        chk("bb_addrB", dmem_addr, 16'h0102);
        chk("bb_wbvB0", wb_valid,  0);
        dmem_ack = 1; dmem_rdata = 16'hBBBB;
        cyc();
        clr_in();
        #1;
        chk("bb_wbvB",  wb_valid,     1);
        chk("bb_mdatB", memData_out,  16'hBBBB);
        chk("bb_calcB", calcData_out, 16'h0102);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
